// File: rtl/hid_key_scheduler.sv
// rtl/hid_key_scheduler.sv - key event scheduler between the MCU byte link and hid
//
// Keyboard frames (command 0x01) from the MCU are absorbed into an event FIFO
// and re-injected to hid as single-event keyboard frames. Successive injected
// events are spaced by at least HOLD_CYCLES so that every press and release is
// seen by the matrix scan. All other frames pass through to hid, one cycle late.
//
// Optional build macro: HID_KEY_SCHEDULER_STATS_EN adds the ovf_count and
// orphan_count statistics outputs.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   mcu_strobe/start/data  upstream byte link (start marks a frame command)
//   hid_strobe/start/data  byte stream consumed by hid
//   fifo_level             number of queued key events
//   busy                   FIFO non-empty, injection in progress or hold running
//   ovf_count              (stats) events dropped because the FIFO was full
//   orphan_count           (stats) non-start bytes dropped outside any frame

module hid_key_scheduler #(
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 1500000,
  parameter int GAP_CYCLES  = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        mcu_strobe,
  input  logic                        mcu_start,
  input  logic [7:0]                  mcu_data,
  output logic                        hid_strobe,
  output logic                        hid_start,
  output logic [7:0]                  hid_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy
`ifdef HID_KEY_SCHEDULER_STATS_EN
  ,
  output logic [15:0]                 ovf_count,
  output logic [15:0]                 orphan_count
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    KBD_CMD  = 8'h01;

  typedef enum logic [1:0] {F_IDLE, F_KBD, F_FWD} frame_state_t;
  typedef enum logic [1:0] {I_IDLE, I_CMD, I_DATA} inj_state_t;

  frame_state_t frame_state, frame_next;
  inj_state_t   inj_state, inj_next;

  logic [GW-1:0] gap_cnt, gap_next;
  logic [HW-1:0] hold_cnt;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Skid entries hold {start, data}; entry 0 is the oldest.
  logic [8:0]    skid0, skid1;
  logic [1:0]    skid_cnt;
  logic          skid_busy;

  logic          fwd, push, do_push, pop, hold_load, eligible;
  logic          skid_push, skid_pop;
  logic          out_strobe, out_start;
  logic [7:0]    out_data;

  assign fifo_full  = (fifo_count == FULL_LVL);
  assign fifo_empty = (fifo_count == '0);
  assign skid_busy  = (skid_cnt != 2'd0);

  // A full FIFO still accepts a push when the head is popped the same cycle.
  assign do_push = push && (!fifo_full || pop);

  // Frame classification of the upstream byte.
  always_comb begin
    frame_next = frame_state;
    gap_next   = gap_cnt;
    fwd        = 1'b0;
    push       = 1'b0;
    if (mcu_strobe && mcu_start) begin
      gap_next = '0;
      if (mcu_data == KBD_CMD) begin
        frame_next = F_KBD;
      end else begin
        frame_next = F_FWD;
        fwd        = 1'b1;
      end
    end else if (mcu_strobe) begin
      case (frame_state)
        F_KBD:   push = 1'b1;
        F_FWD: begin
          fwd      = 1'b1;
          gap_next = '0;
        end
        default: ;
      endcase
    end else if (frame_state == F_FWD) begin
      // The frame closes on the edge that completes GAP_CYCLES idle cycles,
      // so a byte arriving right after that many idle cycles is an orphan.
      if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
        frame_next = F_IDLE;
        gap_next   = '0;
      end else begin
        gap_next = gap_cnt + GW'(1);
      end
    end
  end

  assign eligible = !fifo_empty && (hold_cnt == '0) && !skid_busy && !mcu_strobe &&
                    ((frame_state == F_IDLE) || (frame_state == F_KBD));

  // Forwarded bytes are parked while an injected frame owns the output or
  // while older parked bytes are still waiting, which keeps them in order.
  assign skid_push = fwd && ((inj_state != I_IDLE) || skid_busy);

  // Injection sequencing and output selection.
  always_comb begin
    inj_next   = inj_state;
    out_strobe = 1'b0;
    out_start  = 1'b0;
    out_data   = '0;
    pop        = 1'b0;
    hold_load  = 1'b0;
    skid_pop   = 1'b0;
    case (inj_state)
      I_CMD: begin
        out_strobe = 1'b1;
        out_data   = fifo_mem[rd_ptr];
        pop        = 1'b1;
        hold_load  = 1'b1;
        inj_next   = I_DATA;
      end
      I_DATA: begin
        inj_next = I_IDLE;
        if (skid_busy) begin
          out_strobe = 1'b1;
          out_start  = skid0[8];
          out_data   = skid0[7:0];
          skid_pop   = 1'b1;
        end
      end
      default: begin
        if (skid_busy) begin
          out_strobe = 1'b1;
          out_start  = skid0[8];
          out_data   = skid0[7:0];
          skid_pop   = 1'b1;
        end else if (fwd) begin
          out_strobe = 1'b1;
          out_start  = mcu_start;
          out_data   = mcu_data;
        end else if (eligible) begin
          out_strobe = 1'b1;
          out_start  = 1'b1;
          out_data   = KBD_CMD;
          inj_next   = I_CMD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_state <= F_IDLE;
      inj_state   <= I_IDLE;
      gap_cnt     <= '0;
    end else begin
      frame_state <= frame_next;
      inj_state   <= inj_next;
      gap_cnt     <= gap_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hid_strobe <= 1'b0;
      hid_start  <= 1'b0;
      hid_data   <= '0;
      hold_cnt   <= '0;
    end else begin
      hid_strobe <= out_strobe;
      hid_start  <= out_start;
      hid_data   <= out_data;
      if (hold_load) begin
        hold_cnt <= HW'(HOLD_CYCLES - 1);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + LW'(1);
        2'b01:   fifo_count <= fifo_count - LW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= mcu_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= 2'd0;
    end else begin
      case ({skid_push, skid_pop})
        2'b10: begin
          if (skid_cnt == 2'd0) skid0 <= {mcu_start, mcu_data};
          else                  skid1 <= {mcu_start, mcu_data};
          skid_cnt <= skid_cnt + 2'd1;
        end
        2'b01: begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end
        2'b11: begin
          if (skid_cnt == 2'd1) begin
            skid0 <= {mcu_start, mcu_data};
          end else begin
            skid0 <= skid1;
            skid1 <= {mcu_start, mcu_data};
          end
        end
        default: ;
      endcase
    end
  end

  assign fifo_level = fifo_count;
  assign busy       = !fifo_empty || (inj_state != I_IDLE) || (hold_cnt != '0);

`ifdef HID_KEY_SCHEDULER_STATS_EN
  logic ovf, orphan;

  assign ovf    = push && fifo_full && !pop;
  assign orphan = mcu_strobe && !mcu_start && (frame_state == F_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_count    <= '0;
      orphan_count <= '0;
    end else begin
      if (ovf && (ovf_count != 16'hFFFF))       ovf_count    <= ovf_count + 16'd1;
      if (orphan && (orphan_count != 16'hFFFF)) orphan_count <= orphan_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hid_key_scheduler.sv
// tb/tb_hid_key_scheduler.sv - directed self-checking bench for hid_key_scheduler
//
// Drives MCU frames, records every hid byte with the cycle it appeared on,
// and compares against hand-derived sequences (HOLD_CYCLES=100, GAP_CYCLES=8,
// FIFO_DEPTH=4).

module tb_hid_key_scheduler;

  localparam int FIFO_DEPTH  = 4;
  localparam int HOLD_CYCLES = 100;
  localparam int GAP_CYCLES  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mcu_strobe = 1'b0;
  logic       mcu_start = 1'b0;
  logic [7:0] mcu_data = 8'h00;
  logic       hid_strobe, hid_start;
  logic [7:0] hid_data;
  logic [2:0] fifo_level;
  logic       busy;
`ifdef HID_KEY_SCHEDULER_STATS_EN
  logic [15:0] ovf_count, orphan_count;
`endif

  hid_key_scheduler #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mcu_strobe  (mcu_strobe),
    .mcu_start   (mcu_start),
    .mcu_data    (mcu_data),
    .hid_strobe  (hid_strobe),
    .hid_start   (hid_start),
    .hid_data    (hid_data),
    .fifo_level  (fifo_level),
    .busy        (busy)
`ifdef HID_KEY_SCHEDULER_STATS_EN
    ,
    .ovf_count   (ovf_count),
    .orphan_count(orphan_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         hq_stamp[$];
  logic [8:0] hq_byte[$];
  always @(negedge clk) begin
    if (hid_strobe) begin
      hq_stamp.push_back(cyc);
      hq_byte.push_back({hid_start, hid_data});
    end
  end

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic start, input logic [7:0] data, output int stamp);
    mcu_strobe = 1'b1;
    mcu_start  = start;
    mcu_data   = data;
    tick();
    stamp      = cyc;
    mcu_strobe = 1'b0;
    mcu_start  = 1'b0;
    mcu_data   = 8'h00;
  endtask

  task automatic check_entry(input string tag, input int idx, input logic [8:0] exp_byte,
                             input int exp_stamp);
    logic [8:0] b;
    int         s;
    b = 9'h1FF;
    s = -1;
    if (idx < hq_byte.size()) begin
      b = hq_byte[idx];
      s = hq_stamp[idx];
    end
    check({tag, "_byte"}, 32'(b), 32'(exp_byte));
    check({tag, "_cycle"}, s, exp_stamp);
  endtask

  task automatic wait_entries(input int n, input int budget);
    int k;
    k = 0;
    while (hq_byte.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    int s0, s1, s2, e, t;
    int st[4];
    logic [7:0] mouse[4];
    logic [7:0] ev[6];
    int n;

    // Reset state
    reset = 1'b1;
    tick(3);
    check("rst_hid_strobe", 32'(hid_strobe), 32'd0);
    check("rst_hid_start", 32'(hid_start), 32'd0);
    check("rst_hid_data", 32'(hid_data), 32'd0);
    check("rst_fifo_level", 32'(fifo_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
`ifdef HID_KEY_SCHEDULER_STATS_EN
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    check("rst_orphan_count", 32'(orphan_count), 32'd0);
`endif
    reset = 1'b0;
    tick(2);

    // Key timing: press then release, second frame waits out the hold
    hq_stamp.delete(); hq_byte.delete();
    send(1'b1, 8'h01, s0);
    tick();
    send(1'b0, 8'h04, s1);
    check("key_level_after_push", 32'(fifo_level), 32'd1);
    tick(5);
    send(1'b0, 8'h84, s2);
    wait_entries(4, 300);
    check("key_entry_count", hq_byte.size(), 4);
    check_entry("key_cmd0", 0, 9'h101, s1 + 1);
    check_entry("key_data0", 1, 9'h004, s1 + 2);
    check_entry("key_cmd1", 2, 9'h101, s1 + 2 + HOLD_CYCLES);
    check_entry("key_data1", 3, 9'h084, s1 + 3 + HOLD_CYCLES);
    wait_idle("key_idle", 300);

    // Mouse passthrough: four bytes forwarded one cycle late
    hq_stamp.delete(); hq_byte.delete();
    mouse[0] = 8'h02; mouse[1] = 8'h01; mouse[2] = 8'h10; mouse[3] = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      send(i == 0, mouse[i], st[i]);
      tick();
    end
    tick(2);
    check("mouse_entry_count", hq_byte.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_entry($sformatf("mouse%0d", i), i, {i == 0, mouse[i]}, st[i]);
    end
    check("mouse_fifo_level", 32'(fifo_level), 32'd0);

    // Gap closure: 7 idle cycles keep the frame open, 8 close it
    hq_stamp.delete(); hq_byte.delete();
    send(1'b1, 8'h02, s0);
    send(1'b0, 8'h01, s1);
    tick(7);
    send(1'b0, 8'h66, s2);
    tick(8);
    send(1'b0, 8'h55, t);
    tick(3);
    check("gap_entry_count", hq_byte.size(), 3);
    check_entry("gap_cmd", 0, 9'h102, s0);
    check_entry("gap_b1", 1, 9'h001, s1);
    check_entry("gap_open", 2, 9'h066, s2);
`ifdef HID_KEY_SCHEDULER_STATS_EN
    check("gap_orphan_count", 32'(orphan_count), 32'd1);
`endif

    // Skid buffer: forwarded bytes during I_CMD and I_DATA follow the event
    hq_stamp.delete(); hq_byte.delete();
    send(1'b1, 8'h01, t);
    tick();
    send(1'b0, 8'h2A, e);
    tick();
    send(1'b1, 8'h03, t);
    send(1'b0, 8'h00, t);
    tick(3);
    check("skid_entry_count", hq_byte.size(), 4);
    check_entry("skid_cmd", 0, 9'h101, e + 1);
    check_entry("skid_event", 1, 9'h02A, e + 2);
    check_entry("skid_fwd_cmd", 2, 9'h103, e + 3);
    check_entry("skid_fwd_data", 3, 9'h000, e + 4);
    wait_idle("skid_idle", 300);
    tick(GAP_CYCLES + 2);

    // Overflow: depth 4, five more events arrive during the first hold
    hq_stamp.delete(); hq_byte.delete();
    ev[0] = 8'h11; ev[1] = 8'h12; ev[2] = 8'h13; ev[3] = 8'h94; ev[4] = 8'h15; ev[5] = 8'h16;
    send(1'b1, 8'h01, t);
    tick();
    send(1'b0, ev[0], e);
    tick(3);
    for (int i = 1; i < 6; i++) begin
      send(1'b0, ev[i], t);
      tick();
    end
    check("ovf_fifo_level", 32'(fifo_level), 32'd4);
`ifdef HID_KEY_SCHEDULER_STATS_EN
    check("ovf_count", 32'(ovf_count), 32'd1);
`endif
    wait_entries(10, 700);
    for (int k = 0; k < 5; k++) begin
      check_entry($sformatf("ovf_cmd%0d", k), 2 * k, 9'h101, e + 1 + k * (HOLD_CYCLES + 1));
      check_entry($sformatf("ovf_ev%0d", k), 2 * k + 1, {1'b0, ev[k]},
                  e + 2 + k * (HOLD_CYCLES + 1));
    end
    tick(150);
    check("ovf_sixth_dropped", hq_byte.size(), 10);
    wait_idle("ovf_idle", 300);

    // Reset during I_CMD aborts the frame
    hq_stamp.delete(); hq_byte.delete();
    send(1'b0, 8'h21, e);
    tick();
    check("rmid_cmd_start", 32'(hid_start), 32'd1);
    check("rmid_cmd_data", 32'(hid_data), 32'h01);
    reset = 1'b1;
    tick();
    check("rmid_hid_strobe", 32'(hid_strobe), 32'd0);
    check("rmid_fifo_level", 32'(fifo_level), 32'd0);
    check("rmid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    n = hq_byte.size();
    tick(5);
    check("rmid_no_more_bytes", hq_byte.size(), n);
`ifdef HID_KEY_SCHEDULER_STATS_EN
    check("rmid_ovf_count", 32'(ovf_count), 32'd0);
    check("rmid_orphan_count", 32'(orphan_count), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
